traffic_safety_monitor: RTL and testbench



---
 rtl/traffic_mon_pkg.sv | 33 +++
 rtl/lamp_decode.sv | 23 ++
 rtl/traffic_safety_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_traffic_safety_monitor.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_mon_pkg.sv
// Shared types and constants for the traffic safety monitor.
// Lamp-state encoding, fault codes, monitor states and the legal-step rule.
package traffic_mon_pkg;

  typedef enum logic [1:0] {
    RED     = 2'd0,
    YELLOW  = 2'd1,
    GREEN   = 2'd2,
    ILLEGAL = 2'd3
  } lamp_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ENCODING = 3'd2;
  localparam logic [2:0] FC_SEQUENCE = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_WDOG     = 3'd5;

  typedef enum logic [1:0] {
    StArm,
    StMonitor,
    StFault
  } mon_state_e;

  // Holding a state is always allowed; otherwise only G->Y, Y->R, R->G.
  function automatic logic step_ok(lamp_e prev, lamp_e cur);
    return (prev == cur) ||
           (prev == GREEN && cur == YELLOW) ||
           (prev == YELLOW && cur == RED) ||
           (prev == RED && cur == GREEN);
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Decodes one approach's three lamp lines into a lamp state plus a legal flag.
module lamp_decode
  import traffic_mon_pkg::*;
(
  input  logic  green,
  input  logic  yellow,
  input  logic  red,
  output lamp_e state,
  output logic  legal
);

  always_comb begin
    state = ILLEGAL;
    legal = 1'b1;
    unique case ({green, yellow, red})
      3'b100:  state = GREEN;
      3'b010:  state = YELLOW;
      3'b001:  state = RED;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Conflict monitor and lamp driver behind the two-way traffic controller.
// Illegal signalling latches a fault code and forces flashing red until cleared.
module traffic_safety_monitor
  import traffic_mon_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned MAX_DWELL  = 64,
  parameter int unsigned GLITCH_CYC = 2,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       green_1,
  input  logic       yellow_1,
  input  logic       red_1,
  input  logic       green_2,
  input  logic       yellow_2,
  input  logic       red_2,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       lamp_g1,
  output logic       lamp_y1,
  output logic       lamp_r1,
  output logic       lamp_g2,
  output logic       lamp_y2,
  output logic       lamp_r2,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned WW = $clog2(MAX_DWELL + 1);
  localparam int unsigned GW = $clog2(GLITCH_CYC + 1);
  localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [5:0] LampsRedRed = 6'b001_001;  // {g1,y1,r1,g2,y2,r2}

  mon_state_e     state_q, state_d;
  logic [6:0]     in_q, in_prev_q;  // {g1,y1,r1,g2,y2,r2,enable}
  logic [5:0]     lamp_q, lamp_d;
  lamp_e          last_q [2];
  lamp_e          last_d [2];
  lamp_e          cur    [2];
  logic           legal  [2];
  logic [YW-1:0]  ycnt_q [2];
  logic [YW-1:0]  ycnt_d [2];
  logic [GW-1:0]  glitch_q, glitch_d, glitch_next;
  logic [WW-1:0]  wd_q, wd_d, wd_next;
  logic [FW-1:0]  flash_q, flash_d;
  logic           phase_q, phase_d;
  logic [2:0]     code_q, code_d, viol;
  logic [7:0]     count_q, count_d;
  logic           both_legal, conflict, seq_bad, short_y;

  lamp_decode u_dec1 (
    .green  (in_q[6]),
    .yellow (in_q[5]),
    .red    (in_q[4]),
    .state  (cur[0]),
    .legal  (legal[0])
  );

  lamp_decode u_dec2 (
    .green  (in_q[3]),
    .yellow (in_q[2]),
    .red    (in_q[1]),
    .state  (cur[1]),
    .legal  (legal[1])
  );

  always_comb begin
    state_d  = state_q;
    lamp_d   = lamp_q;
    last_d   = last_q;
    ycnt_d   = ycnt_q;
    glitch_d = glitch_q;
    wd_d     = wd_q;
    flash_d  = flash_q;
    phase_d  = phase_q;
    code_d   = code_q;
    count_d  = count_q;
    viol     = FC_NONE;

    both_legal  = legal[0] && legal[1];
    conflict    = both_legal && cur[0] != RED && cur[1] != RED;
    glitch_next = glitch_q + GW'(1);
    // Any change (lamps or enable) restarts the dwell; disabled cycles just hold it.
    if (in_q != in_prev_q) wd_next = '0;
    else if (in_q[0])      wd_next = wd_q + WW'(1);
    else                   wd_next = wd_q;

    seq_bad = 1'b0;
    short_y = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!step_ok(last_q[i], cur[i])) seq_bad = 1'b1;
      if (last_q[i] == YELLOW && cur[i] == RED && ycnt_q[i] < YW'(MIN_YELLOW)) short_y = 1'b1;
    end

    unique case (state_q)
      StArm: begin
        lamp_d   = LampsRedRed;
        glitch_d = '0;
        wd_d     = '0;
        ycnt_d   = '{default: '0};
        if (both_legal && !conflict) begin
          state_d = StMonitor;
          lamp_d  = in_q[6:1];
          last_d  = cur;
          for (int i = 0; i < 2; i++) ycnt_d[i] = (cur[i] == YELLOW) ? YW'(1) : '0;
        end
      end
      StMonitor: begin
        if (both_legal) begin
          if (conflict)     viol = FC_CONFLICT;
          else if (seq_bad) viol = FC_SEQUENCE;
          else if (short_y) viol = FC_SHORT_Y;
        end else if (glitch_next >= GW'(GLITCH_CYC)) begin
          viol = FC_ENCODING;
        end
        if (viol == FC_NONE && wd_next == WW'(MAX_DWELL)) viol = FC_WDOG;

        if (viol != FC_NONE) begin
          state_d  = StFault;
          code_d   = viol;
          count_d  = (count_q == 8'hff) ? count_q : count_q + 8'd1;
          lamp_d   = LampsRedRed;
          phase_d  = 1'b1;
          flash_d  = '0;
          glitch_d = '0;
          wd_d     = '0;
          ycnt_d   = '{default: '0};
        end else if (both_legal) begin
          lamp_d   = in_q[6:1];
          last_d   = cur;
          glitch_d = '0;
          wd_d     = wd_next;
          for (int i = 0; i < 2; i++) begin
            if (cur[i] != YELLOW)                 ycnt_d[i] = '0;
            else if (last_q[i] != YELLOW)         ycnt_d[i] = YW'(1);
            else if (ycnt_q[i] != YW'(MIN_YELLOW)) ycnt_d[i] = ycnt_q[i] + YW'(1);
          end
        end else begin
          // Tolerated glitch: lamps and last_legal hold.
          glitch_d = glitch_next;
          wd_d     = wd_next;
        end
      end
      StFault: begin
        flash_d = flash_q + FW'(1);
        if (flash_q == FW'(FLASH_HALF - 1)) begin
          flash_d = '0;
          phase_d = !phase_q;
        end
        lamp_d = {2'b00, phase_d, 2'b00, phase_d};
        if (clear_fault && cur[0] == RED && cur[1] == RED) begin
          state_d  = StMonitor;
          lamp_d   = in_q[6:1];
          last_d   = '{RED, RED};
          code_d   = FC_NONE;
          glitch_d = '0;
          wd_d     = '0;
          flash_d  = '0;
          ycnt_d   = '{default: '0};
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StArm;
      in_q      <= '0;
      in_prev_q <= '0;
      lamp_q    <= LampsRedRed;
      last_q    <= '{RED, RED};
      ycnt_q    <= '{default: '0};
      glitch_q  <= '0;
      wd_q      <= '0;
      flash_q   <= '0;
      phase_q   <= 1'b0;
      code_q    <= FC_NONE;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_q      <= {green_1, yellow_1, red_1, green_2, yellow_2, red_2, enable};
      in_prev_q <= in_q;
      lamp_q    <= lamp_d;
      last_q    <= last_d;
      ycnt_q    <= ycnt_d;
      glitch_q  <= glitch_d;
      wd_q      <= wd_d;
      flash_q   <= flash_d;
      phase_q   <= phase_d;
      code_q    <= code_d;
      count_q   <= count_d;
    end
  end

  assign {lamp_g1, lamp_y1, lamp_r1, lamp_g2, lamp_y2, lamp_r2} = lamp_q;
  assign fault       = (state_q == StFault);
  assign fault_code  = code_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Scoreboard bench: a per-cycle behavioural model queues expected outputs and a
// monitor compares them one clock later.
module tb_traffic_safety_monitor;

  localparam int MIN_YELLOW = 4;
  localparam int MAX_DWELL  = 64;
  localparam int GLITCH_CYC = 2;
  localparam int FLASH_HALF = 4;
  localparam logic [5:0] RR = 6'b001_001;
  localparam int MArm = 0, MMon = 1, MFault = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic green_1 = 0, yellow_1 = 0, red_1 = 0, green_2 = 0, yellow_2 = 0, red_2 = 0;
  logic enable = 0, clear_fault = 0;
  logic lamp_g1, lamp_y1, lamp_r1, lamp_g2, lamp_y2, lamp_r2, fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  traffic_safety_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_DWELL  (MAX_DWELL),
    .GLITCH_CYC (GLITCH_CYC),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .green_1     (green_1),
    .yellow_1    (yellow_1),
    .red_1       (red_1),
    .green_2     (green_2),
    .yellow_2    (yellow_2),
    .red_2       (red_2),
    .enable      (enable),
    .clear_fault (clear_fault),
    .lamp_g1     (lamp_g1),
    .lamp_y1     (lamp_y1),
    .lamp_r1     (lamp_r1),
    .lamp_g2     (lamp_g2),
    .lamp_y2     (lamp_y2),
    .lamp_r2     (lamp_r2),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] lamps;
    logic       flt;
    logic [2:0] code;
    logic [7:0] count;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_got;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  // Reference model: lamp states as 0=R 1=Y 2=G 3=illegal.
  int         m_st, m_glen, m_wd, m_code, m_count, m_ft;
  int         m_last[2];
  int         m_ylen[2];
  logic [6:0] m_in, m_prev;
  logic [5:0] m_lamps;

  function automatic int dec(logic [2:0] gyr);
    if ($countones(gyr) != 1) return 3;
    if (gyr[2]) return 2;
    if (gyr[1]) return 1;
    return 0;
  endfunction

  function automatic int next_of(int s);
    return (s == 0) ? 2 : (s == 2) ? 1 : 0;
  endfunction

  function automatic logic [2:0] enc(int s);
    case (s)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [6:0] vec(int a1, int a2, logic en);
    return {enc(a1), enc(a2), en};
  endfunction

  task automatic model_step(input logic clr, input logic rst, input logic [6:0] v);
    int  d[2];
    int  wd_new, glen_new, code;
    bit  legal, conflict, bad_seq, short_y;
    d[0]     = dec(m_in[6:4]);
    d[1]     = dec(m_in[3:1]);
    legal    = d[0] != 3 && d[1] != 3;
    conflict = legal && d[0] != 0 && d[1] != 0;
    if (rst) begin
      m_st = MArm; m_lamps = RR; m_code = 0; m_count = 0;
      m_wd = 0; m_glen = 0; m_ylen = '{0, 0}; m_last = '{0, 0};
    end else if (m_st == MArm) begin
      if (legal && !conflict) begin
        m_st = MMon;
        m_lamps = m_in[6:1];
        for (int i = 0; i < 2; i++) begin
          m_last[i] = d[i];
          m_ylen[i] = (d[i] == 1) ? 1 : 0;
        end
      end
    end else if (m_st == MMon) begin
      wd_new   = (m_in != m_prev) ? 0 : (m_in[0] ? m_wd + 1 : m_wd);
      glen_new = legal ? 0 : m_glen + 1;
      bad_seq  = 0;
      short_y  = 0;
      for (int i = 0; i < 2; i++) begin
        if (legal && d[i] != m_last[i] && d[i] != next_of(m_last[i])) bad_seq = 1;
        if (legal && m_last[i] == 1 && d[i] == 0 && m_ylen[i] < MIN_YELLOW) short_y = 1;
      end
      code = conflict ? 1 : (glen_new >= GLITCH_CYC) ? 2 : bad_seq ? 3 : short_y ? 4 :
             (wd_new >= MAX_DWELL) ? 5 : 0;
      if (code != 0) begin
        m_st = MFault; m_code = code; m_ft = 0; m_lamps = RR;
        if (m_count < 255) m_count++;
        m_wd = 0; m_glen = 0; m_ylen = '{0, 0};
      end else if (legal) begin
        m_lamps = m_in[6:1];
        for (int i = 0; i < 2; i++) begin
          m_ylen[i] = (d[i] == 1) ? ((m_last[i] == 1) ? m_ylen[i] + 1 : 1) : 0;
          m_last[i] = d[i];
        end
        m_glen = 0;
        m_wd = wd_new;
      end else begin
        m_glen = glen_new;
        m_wd = wd_new;
      end
    end else begin
      m_ft++;
      if (clr && d[0] == 0 && d[1] == 0) begin
        m_st = MMon; m_lamps = m_in[6:1]; m_last = '{0, 0}; m_code = 0;
        m_wd = 0; m_glen = 0; m_ylen = '{0, 0};
      end else begin
        m_lamps = (((m_ft / FLASH_HALF) % 2) == 0) ? RR : 6'b0;
      end
    end
    m_prev = rst ? 7'b0 : m_in;
    m_in   = rst ? 7'b0 : v;
  endtask

  task automatic drive(input logic [6:0] v, input logic clr, input logic rst);
    obs_t e;
    @(negedge clk);
    {green_1, yellow_1, red_1, green_2, yellow_2, red_2, enable} = v;
    clear_fault = clr;
    reset = rst;
    model_step(clr, rst, v);
    e.lamps = m_lamps;
    e.flt   = (m_st == MFault);
    e.code  = 3'(m_code);
    e.count = 8'(m_count);
    exp_q.push_back(e);
  endtask

  task automatic hold(input int a1, input int a2, input logic en, input int n,
                      input logic clr = 1'b0);
    repeat (n) drive(vec(a1, a2, en), clr, 1'b0);
  endtask

  // Monitor: outputs settle one delta after the edge, so compare at edge + 1.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {lamp_g1, lamp_y1, lamp_r1, lamp_g2, lamp_y2, lamp_r2,
                   fault, fault_code, fault_count};
        n_checks++;
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL cyc%0d outputs: got lamps=%b fault=%b code=%0d count=%0d, want lamps=%b fault=%b code=%0d count=%0d",
                   n_cyc, mon_got.lamps, mon_got.flt, mon_got.code, mon_got.count,
                   mon_exp.lamps, mon_exp.flt, mon_exp.code, mon_exp.count);
        end
      end
    end
  end

  int         ra[2];
  int         rsel, ri;
  logic [6:0] rv;
  logic       ren, rclr, rrst;

  initial begin
    m_st = MArm; m_in = '0; m_prev = '0; m_lamps = RR;
    m_glen = 0; m_wd = 0; m_code = 0; m_count = 0; m_ft = 0;
    m_last = '{0, 0}; m_ylen = '{0, 0};

    repeat (3) drive(7'b0, 1'b0, 1'b1);

    // Legal cycle, twice round.
    repeat (2) begin
      hold(2, 0, 1, 6); hold(1, 0, 1, 4); hold(0, 0, 1, 2);
      hold(0, 2, 1, 6); hold(0, 1, 1, 4); hold(0, 0, 1, 2);
    end

    // Conflict, flashing, ignored clear, then a valid clear.
    hold(2, 0, 1, 2); hold(2, 2, 1, 1); hold(0, 0, 1, 10);
    hold(2, 0, 1, 1); hold(2, 0, 1, 1, 1'b1); hold(2, 0, 1, 3);
    hold(0, 0, 1, 1); hold(0, 0, 1, 1, 1'b1); hold(0, 0, 1, 2);

    // Short yellow faults; exactly MIN_YELLOW does not.
    hold(2, 0, 1, 3); hold(1, 0, 1, 2); hold(0, 0, 1, 3);
    hold(0, 0, 1, 1, 1'b1); hold(2, 0, 1, 3); hold(1, 0, 1, 4); hold(0, 0, 1, 3);

    // Watchdog fires when enabled; enable low holds it off.
    hold(0, 2, 1, 70); hold(0, 0, 1, 2); hold(0, 0, 1, 1, 1'b1);
    hold(0, 0, 0, 100); hold(0, 2, 1, 3);

    // One-cycle encoding glitch holds; two cycles faults.
    hold(3, 2, 1, 1); hold(0, 2, 1, 3); hold(3, 2, 1, 2); hold(0, 0, 1, 6);

    // Reset while in FAULT.
    hold(0, 0, 1, 2, 1'b0);
    repeat (2) drive(vec(0, 0, 1), 1'b0, 1'b1);
    hold(0, 0, 1, 3); hold(2, 0, 1, 3);

    // Random legal walk with occasional garbage, clears and resets.
    ra = '{2, 0};
    for (int k = 0; k < 500; k++) begin
      rsel = $urandom_range(99);
      if (rsel < 20) begin
        ri = $urandom_range(1);
        ra[ri] = next_of(ra[ri]);
      end else if (rsel < 25) begin
        ra = '{0, 0};
      end
      ren  = ($urandom_range(9) != 0);
      rv   = vec(ra[0], ra[1], ren);
      if ($urandom_range(19) == 0) rv[6:1] = 6'($urandom);
      rclr = ($urandom_range(7) == 0);
      rrst = ($urandom_range(199) == 0);
      drive(rv, rclr, rrst);
    end

    hold(0, 0, 1, 2);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
